// File: rtl/matvec_sequencer.sv
// matvec_sequencer: go-triggered FIFO fill, skewed stream into the MAC array,
// then Avalon-MM write-back of the FIFO_DEPTH accumulators.
module matvec_sequencer #(
    parameter int DATA_WIDTH       = 8,
    parameter int FIFO_DEPTH       = 8,
    parameter int MEM_ADDR_WIDTH   = 32,
    parameter int MEM_DATA_WIDTH   = 64,
    parameter int RESULT_WIDTH     = 24,
    parameter int RESULT_BASE_ADDR = 9
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 go,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic                                 fill_start,
    input  logic                                 fill_ready,
    output logic [FIFO_DEPTH-1:0]                a_rden,
    input  logic [FIFO_DEPTH-1:0]                a_empty,
    output logic                                 b_rden,
    input  logic                                 b_empty,
    output logic                                 mac_clr,
    output logic [FIFO_DEPTH-1:0]                mac_en,
    input  logic [FIFO_DEPTH*RESULT_WIDTH-1:0]   mac_result,
    output logic [MEM_ADDR_WIDTH-1:0]            address,
    output logic                                 write,
    output logic [MEM_DATA_WIDTH-1:0]            writedata,
    input  logic                                 waitrequest
);
    localparam int CW = $clog2(2*FIFO_DEPTH);
    localparam int RW = RESULT_WIDTH;

    if (DATA_WIDTH < 1 || RESULT_WIDTH > MEM_DATA_WIDTH) begin : g_bad_params
        $error("matvec_sequencer: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, FILL, WAIT_FILL, CLEAR, STREAM, DRAIN, WRITE, DONE} state_t;

    state_t                r_state;
    logic [CW-1:0]         r_k;
    logic [CW-1:0]         r_w;
    logic [FIFO_DEPTH-1:0] r_a_sched;
    logic [FIFO_DEPTH-1:0] r_mac_en;
    logic                  r_b_sched;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;
    logic                  r_fill_start;
    logic                  r_mac_clr;
    logic                  r_write;
    logic [FIFO_DEPTH-1:0] w_a_rden;
    logic                  w_b_rden;
    logic                  w_underflow;
    logic [CW-1:0]         w_k_next;

    // Row r of A is read during stream steps r .. r+FIFO_DEPTH-1 (systolic skew)
    function automatic logic [FIFO_DEPTH-1:0] a_window(input logic [CW-1:0] k);
        a_window = '0;
        for (int r = 0; r < FIFO_DEPTH; r++)
            a_window[r] = (int'(k) >= r) && (int'(k) < r + FIFO_DEPTH);
    endfunction

    // Scheduled reads are gated by emptiness in the same cycle; a gated read is an underflow
    assign w_a_rden    = r_a_sched & ~a_empty;
    assign w_b_rden    = r_b_sched & ~b_empty;
    assign w_underflow = (|(r_a_sched & a_empty)) | (r_b_sched & b_empty);
    assign w_k_next    = r_k + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_w          <= '0;
            r_a_sched    <= '0;
            r_mac_en     <= '0;
            r_b_sched    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_fill_start <= 1'b0;
            r_mac_clr    <= 1'b0;
            r_write      <= 1'b0;
        end else begin
            r_mac_en <= w_a_rden;
            if (w_underflow) r_err <= 1'b1;
            case (r_state)
                IDLE: if (go) begin
                    r_err        <= 1'b0;
                    r_busy       <= 1'b1;
                    r_fill_start <= 1'b1;
                    r_state      <= FILL;
                end
                FILL: begin
                    r_fill_start <= 1'b0;
                    r_state      <= WAIT_FILL;
                end
                WAIT_FILL: if (fill_ready) begin
                    r_mac_clr <= 1'b1;
                    r_state   <= CLEAR;
                end
                CLEAR: begin
                    r_mac_clr <= 1'b0;
                    r_k       <= '0;
                    r_a_sched <= a_window('0);
                    r_b_sched <= 1'b1;
                    r_state   <= STREAM;
                end
                STREAM: if (r_k == CW'(2*FIFO_DEPTH-2)) begin
                    r_a_sched <= '0;
                    r_b_sched <= 1'b0;
                    r_state   <= DRAIN;
                end else begin
                    r_k       <= w_k_next;
                    r_a_sched <= a_window(w_k_next);
                    r_b_sched <= w_k_next < CW'(FIFO_DEPTH);
                end
                DRAIN: begin
                    r_w     <= '0;
                    r_write <= 1'b1;
                    r_state <= WRITE;
                end
                WRITE: if (!waitrequest) begin
                    if (r_w == CW'(FIFO_DEPTH-1)) begin
                        r_write <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_w <= r_w + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign fill_start = r_fill_start;
    assign mac_clr    = r_mac_clr;
    assign mac_en     = r_mac_en;
    assign a_rden     = w_a_rden;
    assign b_rden     = w_b_rden;
    assign write      = r_write;
    // Write data is muxed live: the final accumulate lands at the end of DRAIN
    assign address    = r_write ? MEM_ADDR_WIDTH'(RESULT_BASE_ADDR) + MEM_ADDR_WIDTH'(r_w) : '0;
    assign writedata  = r_write ? MEM_DATA_WIDTH'(mac_result[int'(r_w)*RW +: RW]) : '0;
endmodule
